// File: rtl/psg_bus_pkg.sv
// -----------------------------------------------------------------------------
// psg_bus_pkg
// Shared definitions for the AY/YM2149 bus master:
//   - {BDIR,BC1} bus codes
//   - FSM state enum
//   - 14-bit request record {wr, chip, regn, data}
//   - small max helper used to size the phase counter
// No ports (package).
// -----------------------------------------------------------------------------
package psg_bus_pkg;

    // {BDIR,BC1} codes as seen by the PSG
    localparam logic [1:0] BUS_INACT = 2'b00;
    localparam logic [1:0] BUS_READ  = 2'b01;
    localparam logic [1:0] BUS_WRITE = 2'b10;
    localparam logic [1:0] BUS_LATCH = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_GAP1,
        ST_DATA,
        ST_GAP2
    } state_e;

    // 'reg' is a keyword, so the register-number field is called regn
    typedef struct packed {
        logic       wr;
        logic       chip;
        logic [3:0] regn;
        logic [7:0] data;
    } req_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/psg_bus_master_if.sv
// -----------------------------------------------------------------------------
// psg_bus_master_if
// Groups the request/response handshake and the PSG-side bus of
// psg_bus_master.
//   master modport : view of the bus master (drives REQ_READY, RSP_*, BUSY,
//                    chip selects, BDIR/BC1, DA_O/DA_OE; samples requests, DA_I)
//   slave modport  : view of the requester/PSG side (opposite directions)
// -----------------------------------------------------------------------------
interface psg_bus_master_if;

    logic       REQ_VALID;
    logic       REQ_READY;
    logic       REQ_WR;
    logic       REQ_CHIP;
    logic [3:0] REQ_REG;
    logic [7:0] REQ_DATA;
    logic       RSP_VALID;
    logic [7:0] RSP_DATA;
    logic       BUSY;
    logic       PSG0_CS;
    logic       PSG1_CS;
    logic       BDIR;
    logic       BC1;
    logic [7:0] DA_O;
    logic       DA_OE;
    logic [7:0] DA_I;

    modport master (
        input  REQ_VALID, REQ_WR, REQ_CHIP, REQ_REG, REQ_DATA, DA_I,
        output REQ_READY, RSP_VALID, RSP_DATA, BUSY,
        output PSG0_CS, PSG1_CS, BDIR, BC1, DA_O, DA_OE
    );

    modport slave (
        output REQ_VALID, REQ_WR, REQ_CHIP, REQ_REG, REQ_DATA, DA_I,
        input  REQ_READY, RSP_VALID, RSP_DATA, BUSY,
        input  PSG0_CS, PSG1_CS, BDIR, BC1, DA_O, DA_OE
    );

endinterface

// File: rtl/psg_cmd_fifo.sv
// -----------------------------------------------------------------------------
// psg_cmd_fifo
// Synchronous DEPTH x req_t request FIFO with show-ahead head output.
// Ports:
//   MCLK, RESET   clock, asynchronous active-high reset (pointers only)
//   push_i        write request (ignored when full)
//   push_data_i   record to store
//   pop_i         consume head (ignored when empty)
//   head_o        current head record
//   full_o        no free entry
//   empty_o       no stored entry
// Pointers carry one extra wrap bit to tell full from empty.
// -----------------------------------------------------------------------------
module psg_cmd_fifo
    import psg_bus_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic MCLK,
    input  logic RESET,
    input  logic push_i,
    input  req_t push_data_i,
    input  logic pop_i,
    output req_t head_o,
    output logic full_o,
    output logic empty_o
);

    localparam int AW = $clog2(DEPTH);

    req_t          mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q;
    logic [AW:0]   rd_ptr_q;
    logic          do_push;
    logic          do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    // NOTE: storage is deliberately not reset; the empty flag guarantees a
    // stale entry is never consumed, and skipping reset keeps it plain RAM.
    always_ff @(posedge MCLK) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

endmodule

// File: rtl/psg_bus_master.sv
// -----------------------------------------------------------------------------
// psg_bus_master
// Initiator for the AY/YM2149 BDIR/BC1 bus. Queued register requests are run
// as ADDR -> GAP1 -> DATA -> GAP2 bus cycles to PSG 0 or PSG 1.
// Ports:
//   MCLK   system clock
//   RESET  asynchronous active-high reset
//   bus    psg_bus_master_if.master: request handshake (REQ_*), read response
//          (RSP_*), BUSY, chip selects, BDIR/BC1, DA_O/DA_OE/DA_I
// Optional feature: PSG_READBACK_EN
//   defined   - read requests run a read DATA phase and return RSP_DATA
//   undefined - every request runs as a write, RSP_* tied low, DA_I unused
// All bus outputs are registered and derived from the next state, so they
// change exactly on state boundaries.
// -----------------------------------------------------------------------------
module psg_bus_master
    import psg_bus_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int STROBE_CYC = 8,
    parameter int GAP_CYC    = 2
) (
    input  logic                 MCLK,
    input  logic                 RESET,
    psg_bus_master_if.master     bus
);

    localparam int              CW        = $clog2(max2(STROBE_CYC, GAP_CYC) + 1);
    localparam logic [CW-1:0]   STROBE_LD = CW'(STROBE_CYC - 1);
    localparam logic [CW-1:0]   GAP_LD    = CW'(GAP_CYC - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    req_t          work_q, work_d;
    req_t          push_req;
    req_t          head;
    logic          fifo_full, fifo_empty, pop;
    logic          rd_sel;

    logic [1:0]    code_q, code_d;
    logic          cs0_q, cs0_d, cs1_q, cs1_d;
    logic          oe_q, oe_d;
    logic [7:0]    da_q, da_d;

    assign push_req = '{wr: bus.REQ_WR, chip: bus.REQ_CHIP,
                        regn: bus.REQ_REG, data: bus.REQ_DATA};

    psg_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .MCLK        (MCLK),
        .RESET       (RESET),
        .push_i      (bus.REQ_VALID),
        .push_data_i (push_req),
        .pop_i       (pop),
        .head_o      (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

`ifdef PSG_READBACK_EN
    assign rd_sel = !work_d.wr;
`else
    assign rd_sel = 1'b0;
`endif

    // NOTE: every always_comb output gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        pop     = 1'b0;
        unique case (state_q)
            ST_IDLE: if (!fifo_empty) begin
                pop     = 1'b1;
                work_d  = head;
                state_d = ST_ADDR;
                cnt_d   = STROBE_LD;
            end
            ST_ADDR: if (cnt_q == '0) begin
                state_d = ST_GAP1;
                cnt_d   = GAP_LD;
            end else cnt_d = cnt_q - CW'(1);
            ST_GAP1: if (cnt_q == '0) begin
                state_d = ST_DATA;
                cnt_d   = STROBE_LD;
            end else cnt_d = cnt_q - CW'(1);
            ST_DATA: if (cnt_q == '0) begin
                state_d = ST_GAP2;
                cnt_d   = GAP_LD;
            end else cnt_d = cnt_q - CW'(1);
            ST_GAP2: if (cnt_q == '0) begin
                state_d = ST_IDLE;
            end else cnt_d = cnt_q - CW'(1);
            default: state_d = ST_IDLE;
        endcase
    end

    // Bus drive for the cycle after this edge, decoded from the next state
    always_comb begin
        code_d = BUS_INACT;
        cs0_d  = 1'b0;
        cs1_d  = 1'b0;
        oe_d   = 1'b0;
        da_d   = 8'h00;
        unique case (state_d)
            ST_ADDR: begin
                code_d = BUS_LATCH;
                oe_d   = 1'b1;
                da_d   = {4'h0, work_d.regn};
                cs0_d  = !work_d.chip;
                cs1_d  = work_d.chip;
            end
            ST_DATA: begin
                cs0_d = !work_d.chip;
                cs1_d = work_d.chip;
                if (rd_sel) begin
                    code_d = BUS_READ;
                end else begin
                    code_d = BUS_WRITE;
                    oe_d   = 1'b1;
                    da_d   = work_d.data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
            code_q  <= BUS_INACT;
            cs0_q   <= 1'b0;
            cs1_q   <= 1'b0;
            oe_q    <= 1'b0;
            da_q    <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            code_q  <= code_d;
            cs0_q   <= cs0_d;
            cs1_q   <= cs1_d;
            oe_q    <= oe_d;
            da_q    <= da_d;
        end
    end

`ifdef PSG_READBACK_EN
    logic       rsp_valid_q;
    logic [7:0] rsp_data_q;
    logic       sample_rd;

    // DA_I is captured on the last cycle of the read strobe; the pulse
    // then lands on the first GAP2 cycle.
    assign sample_rd = (state_q == ST_DATA) && (cnt_q == '0) && !work_q.wr;

    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'h00;
        end else begin
            rsp_valid_q <= sample_rd;
            if (sample_rd) rsp_data_q <= bus.DA_I;
        end
    end

    assign bus.RSP_VALID = rsp_valid_q;
    assign bus.RSP_DATA  = rsp_data_q;
`else
    assign bus.RSP_VALID = 1'b0;
    assign bus.RSP_DATA  = 8'h00;
`endif

    assign bus.REQ_READY = !fifo_full;
    assign bus.BUSY      = !fifo_empty || (state_q != ST_IDLE);
    assign bus.BDIR      = code_q[1];
    assign bus.BC1       = code_q[0];
    assign bus.PSG0_CS   = cs0_q;
    assign bus.PSG1_CS   = cs1_q;
    assign bus.DA_OE     = oe_q;
    assign bus.DA_O      = da_q;

endmodule
